// File: rtl/dsp48e2_pkg.sv
// dsp48e2_pkg
// Shared constants for the reduced DSP48E2 slice model:
//   - operand / result widths
//   - OPMODE field codes for the W, X, Y and Z multiplexers
//   - ALUMODE function codes
//   - packed control word carried down the control pipeline
package dsp48e2_pkg;

    localparam int A_W = 30;
    localparam int B_W = 18;
    localparam int P_W = 48;
    localparam int M_W = 45;

    // X mux, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_AB   = 2'b11;

    // Y mux, OPMODE[3:2]
    localparam logic [1:0] Y_ZERO = 2'b00;
    localparam logic [1:0] Y_M    = 2'b01;
    localparam logic [1:0] Y_ONES = 2'b10;
    localparam logic [1:0] Y_C    = 2'b11;

    // Z mux, OPMODE[6:4]
    localparam logic [2:0] Z_ZERO   = 3'b000;
    localparam logic [2:0] Z_P      = 3'b010;
    localparam logic [2:0] Z_C      = 3'b011;
    localparam logic [2:0] Z_PSHIFT = 3'b110;

    // W mux, OPMODE[8:7]
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_P    = 2'b01;
    localparam logic [1:0] W_C    = 2'b11;

    // ALUMODE
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_NEG_ADD = 4'b0001;
    localparam logic [3:0] ALU_NOT_ADD = 4'b0010;
    localparam logic [3:0] ALU_ZSUB    = 4'b0011;

    typedef struct packed {
        logic [8:0] opmode;
        logic [3:0] alumode;
        logic       carryin;
    } ctrl_t;

endpackage

// File: rtl/dsp48e2_preg.sv
// dsp48e2_preg
// Optional pipeline register used for every stage of the slice.
//   clk   : rising-edge clock
//   rst   : synchronous active-high clear (overrides ce)
//   ce    : clock enable, register holds when low
//   d     : WIDTH-bit data in
//   q     : WIDTH-bit data out (d passed straight through when EN == 0)
module dsp48e2_preg #(
    parameter int WIDTH = 1,
    parameter int EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (EN != 0) begin : g_reg
            logic [WIDTH-1:0] r;

            // Reset wins over the enable so a single RST edge flushes the whole pipe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r <= '0;
                end else if (ce) begin
                    r <= d;
                end
            end

            assign q = r;
        end else begin : g_wire
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp48e2.sv
// dsp48e2
// Reduced DSP48E2 slice: registered A/B/C, 27x18 signed multiplier,
// 48-bit W+X+Y+Z adder/subtractor with P feedback.
//   CLK, RST          : clock, synchronous active-high reset
//   A[29:0], B[17:0]  : multiplier operands (A[26:0] signed) / A:B concat
//   C[47:0]           : adder operand
//   CEA..CECTRL       : per-register clock enables
//   OPMODE[8:0]       : {W, Z, Y, X} mux selects
//   ALUMODE[3:0]      : adder function
//   CARRYIN           : adder carry in
//   P[47:0]           : result
module dsp48e2
    import dsp48e2_pkg::*;
#(
    parameter int AREG    = 1,
    parameter int BREG    = 1,
    parameter int CREG    = 1,
    parameter int MREG    = 1,
    parameter int PREG    = 1,
    parameter int CTRLREG = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [P_W-1:0] C,
    input  logic           CEA,
    input  logic           CEB,
    input  logic           CEC,
    input  logic           CEM,
    input  logic           CEP,
    input  logic           CECTRL,
    input  logic [8:0]     OPMODE,
    input  logic [3:0]     ALUMODE,
    input  logic           CARRYIN,
    output logic [P_W-1:0] P
);

    logic [A_W-1:0]       a_q;
    logic [B_W-1:0]       b_q;
    logic [P_W-1:0]       c_q;
    logic [P_W-1:0]       c_m;
    logic [P_W-1:0]       ab_m;
    logic [P_W-1:0]       m_d;
    logic [P_W-1:0]       m_q;
    logic [P_W-1:0]       p_d;
    logic [P_W-1:0]       p_q;
    ctrl_t                ctrl_in;
    ctrl_t                ctrl_q;
    ctrl_t                ctrl_m;
    logic signed [M_W-1:0] product;

    assign ctrl_in = '{opmode: OPMODE, alumode: ALUMODE, carryin: CARRYIN};

    // Input stage: A, B, C and controls all sampled on the same edge.
    dsp48e2_preg #(.WIDTH(A_W),          .EN(AREG))    u_areg    (.clk(CLK), .rst(RST), .ce(CEA),    .d(A),       .q(a_q));
    dsp48e2_preg #(.WIDTH(B_W),          .EN(BREG))    u_breg    (.clk(CLK), .rst(RST), .ce(CEB),    .d(B),       .q(b_q));
    dsp48e2_preg #(.WIDTH(P_W),          .EN(CREG))    u_creg    (.clk(CLK), .rst(RST), .ce(CEC),    .d(C),       .q(c_q));
    dsp48e2_preg #(.WIDTH($bits(ctrl_t)), .EN(CTRLREG)) u_ctrlreg (.clk(CLK), .rst(RST), .ce(CECTRL), .d(ctrl_in), .q(ctrl_q));

    // Only the low 27 bits of A feed the multiplier; the upper bits matter only for A:B.
    assign product = $signed(a_q[26:0]) * $signed(b_q);
    assign m_d     = {{(P_W-M_W){product[M_W-1]}}, product};

    // Multiplier stage. C, A:B and the controls ride alongside M so that
    // everything applied on one edge meets in the adder on the P edge.
    dsp48e2_preg #(.WIDTH(P_W),          .EN(MREG)) u_mreg     (.clk(CLK), .rst(RST), .ce(CEM), .d(m_d),        .q(m_q));
    dsp48e2_preg #(.WIDTH(P_W),          .EN(MREG)) u_cmreg    (.clk(CLK), .rst(RST), .ce(CEM), .d(c_q),        .q(c_m));
    dsp48e2_preg #(.WIDTH(P_W),          .EN(MREG)) u_abmreg   (.clk(CLK), .rst(RST), .ce(CEM), .d({a_q, b_q}), .q(ab_m));
    dsp48e2_preg #(.WIDTH($bits(ctrl_t)), .EN(MREG)) u_ctrlmreg (.clk(CLK), .rst(RST), .ce(CEM), .d(ctrl_q),     .q(ctrl_m));

    // W/X/Y/Z muxes and the ALU. The product is a single value, so it only
    // contributes when both X and Y select M; a lone M select adds nothing.
    always_comb begin
        logic [1:0]     x_sel;
        logic [1:0]     y_sel;
        logic [2:0]     z_sel;
        logic [1:0]     w_sel;
        logic [P_W-1:0] x_val;
        logic [P_W-1:0] y_val;
        logic [P_W-1:0] z_val;
        logic [P_W-1:0] w_val;
        logic [P_W-1:0] prod_val;
        logic [P_W-1:0] sum;

        x_sel    = ctrl_m.opmode[1:0];
        y_sel    = ctrl_m.opmode[3:2];
        z_sel    = ctrl_m.opmode[6:4];
        w_sel    = ctrl_m.opmode[8:7];
        x_val    = '0;
        y_val    = '0;
        z_val    = '0;
        w_val    = '0;
        prod_val = '0;
        p_d      = '0;

        if (x_sel == X_M && y_sel == Y_M) begin
            prod_val = m_q;
        end

        case (x_sel)
            X_P:     x_val = p_q;
            X_AB:    x_val = ab_m;
            default: x_val = '0;
        endcase

        case (y_sel)
            Y_ONES:  y_val = '1;
            Y_C:     y_val = c_m;
            default: y_val = '0;
        endcase

        case (z_sel)
            Z_P:      z_val = p_q;
            Z_C:      z_val = c_m;
            Z_PSHIFT: z_val = $unsigned($signed(p_q) >>> 17);
            default:  z_val = '0;
        endcase

        case (w_sel)
            W_P:     w_val = p_q;
            W_C:     w_val = c_m;
            default: w_val = '0;
        endcase

        sum = w_val + x_val + y_val + prod_val + {{(P_W-1){1'b0}}, ctrl_m.carryin};

        // -Z + S - 1 is the same as S + ~Z in two's complement.
        case (ctrl_m.alumode)
            ALU_ZSUB:    p_d = z_val - sum;
            ALU_NEG_ADD: p_d = ~z_val + sum;
            ALU_NOT_ADD: p_d = ~(z_val + sum);
            default:     p_d = z_val + sum;
        endcase
    end

    dsp48e2_preg #(.WIDTH(P_W), .EN(PREG)) u_preg (.clk(CLK), .rst(RST), .ce(CEP), .d(p_d), .q(p_q));

    assign P = p_q;

endmodule

// File: tb/tb_dsp48e2.sv
// tb_dsp48e2
// Scoreboard bench for the dsp48e2 slice: every applied vector may push an
// expected P along with the edge on which it must appear; a monitor pops and
// compares entries as their edge arrives.
module tb_dsp48e2;

    logic        CLK;
    logic        RST;
    logic [29:0] A;
    logic [17:0] B;
    logic [47:0] C;
    logic        CEA, CEB, CEC, CEM, CEP, CECTRL;
    logic [8:0]  OPMODE;
    logic [3:0]  ALUMODE;
    logic        CARRYIN;
    logic [47:0] P;

    typedef struct {
        int          due;
        string       tag;
        logic [47:0] value;
    } exp_t;

    exp_t expQ[$];
    int   edgeCount   = 0;
    int   vectorCount = 0;
    int   missCount   = 0;

    localparam logic [8:0] OP_MUL     = 9'b00_000_01_01;
    localparam logic [8:0] OP_MUL_C   = 9'b00_011_01_01;
    localparam logic [8:0] OP_ACC     = 9'b00_010_01_01;
    localparam logic [8:0] OP_AB      = 9'b00_000_00_11;
    localparam logic [8:0] OP_W_C     = 9'b11_000_00_00;
    localparam logic [8:0] OP_ONES_C  = 9'b00_011_10_00;
    localparam logic [8:0] OP_LONE_M  = 9'b00_011_00_01;

    dsp48e2 dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .C(C),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CEM(CEM), .CEP(CEP), .CECTRL(CECTRL),
        .OPMODE(OPMODE), .ALUMODE(ALUMODE), .CARRYIN(CARRYIN), .P(P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: P=%h expected %h", tag, got, exp);
        end
    endtask

    // Schedule an expected P for the edge 'offset' edges from now.
    task automatic pushExpect(input int offset, input string tag, input logic [47:0] value);
        exp_t e;
        e.due   = edgeCount + offset;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    // Drive one vector for one edge; its result is due on the third edge.
    task automatic applyStimulus(input logic [29:0] a, input logic [17:0] b, input logic [47:0] c,
                                 input logic [8:0] op, input logic [3:0] alu, input logic cin,
                                 input bit chk, input logic [47:0] exp, input string tag);
        A       = a;
        B       = b;
        C       = c;
        OPMODE  = op;
        ALUMODE = alu;
        CARRYIN = cin;
        if (chk) pushExpect(3, tag, exp);
        @(negedge CLK);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        edgeCount++;
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].due == edgeCount) begin
                checkOutput(expQ[i].tag, P, expQ[i].value);
                expQ.delete(i);
            end
        end
    end

    initial begin
        RST = 1'b1;
        {CEA, CEB, CEC, CEM, CEP, CECTRL} = 6'b111111;
        A = '0; B = '0; C = '0; OPMODE = '0; ALUMODE = '0; CARRYIN = 1'b0;
        pushExpect(1, "reset_p", 48'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Plain multiply
        applyStimulus(30'd2,   18'd3,   48'd1,   OP_MUL, 4'b0000, 1'b0, 1, 48'd6,    "mul_2x3");
        applyStimulus(30'd100, 18'd10,  48'd1,   OP_MUL, 4'b0000, 1'b0, 1, 48'd1000, "mul_100x10");
        applyStimulus(30'd0,   18'd999, 48'd1,   OP_MUL, 4'b0000, 1'b0, 1, 48'd0,    "mul_0x999");

        // Multiply-add with C
        applyStimulus(30'd2,   18'd3,   48'd1,   OP_MUL_C, 4'b0000, 1'b0, 1, 48'd7,    "mac_7");
        applyStimulus(30'd100, 18'd10,  48'd5,   OP_MUL_C, 4'b0000, 1'b0, 1, 48'd1005, "mac_1005");
        applyStimulus(30'd0,   18'd999, 48'd123, OP_MUL_C, 4'b0000, 1'b0, 1, 48'd123,  "mac_123");

        // Signed operands; A[29:27] must not affect the product
        applyStimulus({3'b000, 27'h7FF_FFFB}, 18'd7,      48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'hFFFF_FFFF_FFDD, "signed_m5x7");
        applyStimulus({3'b111, 27'd6},        18'h3FFFC,  48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'hFFFF_FFFF_FFE8, "signed_6xm4");

        // ALU functions with Z = C, S = 30
        applyStimulus(30'd5, 18'd6, 48'd100, OP_MUL_C, 4'b0011, 1'b0, 1, 48'd70,               "sub_70");
        applyStimulus(30'd5, 18'd6, 48'd10,  OP_MUL_C, 4'b0011, 1'b0, 1, 48'hFFFF_FFFF_FFEC,   "sub_m20");
        applyStimulus(30'd5, 18'd6, 48'd100, OP_MUL_C, 4'b0001, 1'b0, 1, 48'hFFFF_FFFF_FFB9,   "negadd_m71");
        applyStimulus(30'd5, 18'd6, 48'd100, OP_MUL_C, 4'b0010, 1'b0, 1, 48'hFFFF_FFFF_FF7D,   "notadd");
        applyStimulus(30'd5, 18'd6, 48'd100, OP_MUL_C, 4'b0000, 1'b1, 1, 48'd131,              "carryin_131");
        applyStimulus(30'd5, 18'd6, 48'd100, OP_MUL_C, 4'b1111, 1'b0, 1, 48'd130,              "alu_other_add");
        applyStimulus(30'd1, 18'd1, 48'hFFFF_FFFF_FFFF, OP_MUL_C, 4'b0000, 1'b0, 1, 48'd0,     "wrap_zero");

        // Other mux sources
        applyStimulus(30'd1, 18'd5, 48'd0,               OP_AB,     4'b0000, 1'b0, 1, 48'h0000_0004_0005, "x_ab");
        applyStimulus(30'd0, 18'd0, 48'h1234_5678_9ABC,  OP_W_C,    4'b0000, 1'b0, 1, 48'h1234_5678_9ABC, "w_c");
        applyStimulus(30'd0, 18'd0, 48'd10,              OP_ONES_C, 4'b0000, 1'b0, 1, 48'd9,              "y_ones");
        applyStimulus(30'd3, 18'd4, 48'd50,              OP_LONE_M, 4'b0000, 1'b0, 1, 48'd50,             "lone_m");

        // Accumulate from a zeroed P
        applyStimulus(30'd0, 18'd0, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd0,  "acc_clear");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 1, 48'd12, "acc_12");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 1, 48'd24, "acc_24");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 1, 48'd36, "acc_36");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 0, 48'd0,  "");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 0, 48'd0,  "");

        // One reset edge in the middle: the whole pipe is flushed
        RST = 1'b1;
        pushExpect(1, "rst_p",      48'd0);
        pushExpect(2, "rst_flush1", 48'd0);
        pushExpect(3, "rst_flush2", 48'd0);
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 0, 48'd0, "");
        RST = 1'b0;
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 1, 48'd12, "acc_post_rst_12");
        applyStimulus(30'd3, 18'd4, 48'd0, OP_ACC, 4'b0000, 1'b0, 1, 48'd24, "acc_post_rst_24");

        // CEP low for two edges while the pipe keeps moving
        applyStimulus(30'd1, 18'd1, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd1, "ce_1");
        applyStimulus(30'd2, 18'd2, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd4, "ce_4");
        applyStimulus(30'd3, 18'd3, 48'd0, OP_MUL, 4'b0000, 1'b0, 0, 48'd0, "");
        applyStimulus(30'd4, 18'd4, 48'd0, OP_MUL, 4'b0000, 1'b0, 0, 48'd0, "");
        CEP = 1'b0;
        pushExpect(1, "cep_hold1", 48'd4);
        applyStimulus(30'd5, 18'd5, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd25, "ce_resume_25");
        pushExpect(1, "cep_hold2", 48'd4);
        applyStimulus(30'd6, 18'd6, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd36, "ce_36");
        CEP = 1'b1;
        applyStimulus(30'd7, 18'd7, 48'd0, OP_MUL, 4'b0000, 1'b0, 1, 48'd49, "ce_49");

        // Drain
        for (int i = 0; i < 4; i++) begin
            applyStimulus(30'd0, 18'd0, 48'd0, OP_MUL, 4'b0000, 1'b0, 0, 48'd0, "");
        end

        // Anything still queued never reached its edge
        while (expQ.size() > 0) begin
            checkOutput({expQ[0].tag, "_timeout"}, 48'hx, expQ[0].value);
            void'(expQ.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
